// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers behind a 7-bit bus address.
// SCL/SDA are oversampled on clk; SDA is open-drain (the block only pulls low).
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR    = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [AW-1:0] loc_addr,
    output logic [7:0]    loc_rdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]             w_byte;

    state_t                 r_state;
    logic [3:0]             r_bitcnt;
    logic [6:0]             r_shift;
    logic [AW-1:0]          r_ptr;
    logic                   r_rw;
    logic                   r_mack;
    logic                   r_sda_oe;
    logic                   r_busy;
    logic                   r_wr_strobe;
    logic [AW-1:0]          r_wr_addr;
    logic [7:0]             r_wr_data;
    logic [7:0]             r_regs [NUM_REGS];

    // Synchronizers idle high so reset never fabricates a START/STOP edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_byte     = {r_shift, w_sda};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_mack      <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= '0;
                r_busy   <= 1'b1;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: if (w_scl_rise) begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_bitcnt <= '0;
                            if (w_byte[7:1] == I2C_ADDR) begin
                                r_state <= ADDR_ACK;
                                r_rw    <= w_byte[0];
                            end else begin
                                r_state <= IGNORE;
                            end
                        end
                    end
                    PTR: if (w_scl_rise) begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_bitcnt <= '0;
                            r_ptr    <= w_byte[AW-1:0];
                            r_state  <= PTR_ACK;
                        end
                    end
                    WDATA: if (w_scl_rise) begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_bitcnt      <= '0;
                            r_regs[r_ptr] <= w_byte;
                            r_wr_strobe   <= 1'b1;
                            r_wr_addr     <= r_ptr;
                            r_wr_data     <= w_byte;
                            r_ptr         <= r_ptr + AW'(1);
                            r_state       <= WDATA_ACK;
                        end
                    end
                    // First fall: pull SDA for the ACK clock; second fall: let go.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                        if (r_bitcnt == 4'd0) begin
                            r_sda_oe <= 1'b1;
                            r_bitcnt <= 4'd1;
                        end else begin
                            r_bitcnt <= '0;
                            r_sda_oe <= 1'b0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                r_shift  <= r_regs[r_ptr][6:0];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                                r_state  <= RDATA;
                            end else if (r_state == ADDR_ACK) begin
                                r_state <= PTR;
                            end else begin
                                r_state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (w_scl_rise) r_bitcnt <= r_bitcnt + 4'd1;
                        if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= '0;
                                r_ptr    <= r_ptr + AW'(1);
                                r_state  <= RDATA_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    // Controller's ACK is latched on the rise, acted on at the fall.
                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack   <= w_sda;
                            r_bitcnt <= 4'd1;
                        end
                        if (w_scl_fall && r_bitcnt == 4'd1) begin
                            r_bitcnt <= '0;
                            if (!r_mack) begin
                                r_shift  <= r_regs[r_ptr][6:0];
                                r_sda_oe <= ~r_regs[r_ptr][7];
                                r_state  <= RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= IGNORE;
                            end
                        end
                    end
                    IGNORE:  r_sda_oe <= 1'b0;
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = r_regs[loc_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C controller model, register mirror
// and queues of expected ACKs, read bytes and write events.
module tb_i2c_target_regs;
    localparam int NREG = 16;
    localparam int Q    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [3:0] loc_addr = '0;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] loc_rdata, wr_data;
    logic [3:0] wr_addr;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target_regs #(.I2C_ADDR(7'h50), .NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .loc_addr(loc_addr), .loc_rdata(loc_rdata), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          oe_cnt = 0;
    logic [7:0]  mregs [NREG];
    logic [3:0]  mptr;
    logic        ack_q [$];
    logic [7:0]  rd_q [$];
    logic [11:0] wr_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (!rst && wr_strobe) begin
            if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_event", {wr_addr, wr_data}, wr_q.pop_front());
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_w(input logic b);
        sda_m = b; wclk(Q); scl_m = 1'b1; wclk(2*Q); scl_m = 1'b0; wclk(Q);
    endtask

    task automatic bit_r(output logic b);
        sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q); b = sda_bus; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(Q); sda_m = 1'b1; wclk(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic a;
        ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) bit_w(b[i]);
        bit_r(a);
        check(tag, a, ack_q.pop_front());
    endtask

    task automatic set_ptr(input logic [7:0] p);
        send_byte(p, 1'b0, "ack_ptr");
        mptr = p[3:0];
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_q.push_back({mptr, d});
        mregs[mptr] = d;
        mptr = mptr + 4'd1;
        send_byte(d, 1'b0, "ack_data");
    endtask

    task automatic rd_byte(input logic ack);
        logic [7:0] got;
        logic       b;
        rd_q.push_back(mregs[mptr]);
        mptr = mptr + 4'd1;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            bit_r(b);
            got = {got[6:0], b};
        end
        bit_w(ack);
        check("rdata", got, rd_q.pop_front());
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            loc_addr = 4'(i);
            #1;
            check(tag, loc_rdata, mregs[i]);
        end
    endtask

    initial begin
        int   oe0;
        logic b;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mptr = '0;
        wclk(4);
        #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        wclk(4);
        check_regs("rst_regs");

        // 1: plain write of two bytes
        i2c_start();
        check("busy_start", busy, 1);
        send_byte(8'hA0, 1'b0, "ack_addr");
        set_ptr(8'h03);
        wr_byte(8'hA5);
        wr_byte(8'h5A);
        check("busy_mid", busy, 1);
        i2c_stop();
        check("busy_stop", busy, 0);
        check_regs("t1_regs");

        // 2: pointer write, repeated START, read two bytes
        i2c_start();
        send_byte(8'hA0, 1'b0, "ack_addr");
        set_ptr(8'h03);
        i2c_start();
        send_byte(8'hA1, 1'b0, "ack_addr_rd");
        rd_byte(1'b0);
        rd_byte(1'b1);
        check("oe_after_nack", sda_oe, 0);
        i2c_stop();

        // 3: foreign address and general call are ignored
        oe0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b1, "nack_addr");
        send_byte(8'hFF, 1'b1, "nack_ignored");
        i2c_stop();
        i2c_start();
        send_byte(8'h00, 1'b1, "nack_gencall");
        i2c_stop();
        check("oe_never", oe_cnt - oe0, 0);
        check_regs("t3_regs");

        // 4: pointer wraps past the last register
        i2c_start();
        send_byte(8'hA0, 1'b0, "ack_addr");
        set_ptr(8'h0F);
        wr_byte(8'h11);
        wr_byte(8'h22);
        i2c_stop();
        check_regs("t4_regs");

        // 6: pointer byte larger than the register count
        i2c_start();
        send_byte(8'hA0, 1'b0, "ack_addr");
        set_ptr(8'h13);
        wr_byte(8'h77);
        i2c_stop();
        check_regs("t6_regs");

        // 5: reset while the target drives the third bit of 0x5A
        i2c_start();
        send_byte(8'hA0, 1'b0, "ack_addr");
        set_ptr(8'h04);
        i2c_start();
        send_byte(8'hA1, 1'b0, "ack_addr_rd");
        bit_r(b); check("rbit7", b, 0);
        bit_r(b); check("rbit6", b, 1);
        sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(Q);
        check("oe_pre_rst", sda_oe, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check("oe_rst", sda_oe, 0);
        check("busy_rst", busy, 0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        mptr = '0;
        check_regs("t5_rst_regs");
        wclk(Q); scl_m = 1'b0; wclk(Q);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0, "ack_addr_post");
        set_ptr(8'h02);
        wr_byte(8'h3C);
        i2c_stop();
        check_regs("t5_regs");

        wclk(4);
        check("wr_q_empty", wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
